test_delay_sink: RTL and testbench
==================================

Name: test_delay_sink

Overview:
- Receiving end of the val/rdy test path. Consumes messages from a source or delay element and checks each against an expected-message table.
- After each accepted message it deasserts in_rdy for a programmable number of cycles. This creates back-pressure from the sink side, the counterpart of delay on the source side.
- Reports completion and the first mismatch. Used in unit-test harnesses after the device under test.

Parameters:
- p_msg_nbits, 8, message width in bits.
- p_num_msgs, 1024, expected-table depth.
- c_index_nbits (derived), $clog2(p_num_msgs), table address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- delay_amt  in  32  cycles in_rdy stays low after each accept.
- num_msgs  in  c_index_nbits+1  number of messages expected; static from reset deassertion to done.
- tbl_wr_en  in  1  expected-table write enable.
- tbl_wr_addr  in  c_index_nbits  write address.
- tbl_wr_data  in  p_msg_nbits  expected message.
- in_val  in  1  input message valid.
- in_rdy  out  1  sink ready.
- in_msg  in  p_msg_nbits  input message.
- done  out  1  all num_msgs messages accepted.
- error  out  1  sticky mismatch flag.
- err_idx  out  c_index_nbits+1  index of the first mismatching message.
- err_got  out  p_msg_nbits  received value of the first mismatch.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state is READY; idx, count, done, error, err_idx and err_got are 0.
  - Table contents are not reset and are retained across reset.
- States (1 bit each from an enum of 3): READY, WAIT, DONE.
- in_rdy is combinational: (state==READY) && (idx<num_msgs). It is 0 in WAIT and DONE.
- Accept condition: in_val && in_rdy.
- On accept:
  - idx <= idx+1.
  - If in_msg != tbl[idx] and error==0, then error<=1, err_idx<=idx, err_got<=in_msg.
  - Later mismatches are ignored; error stays high until reset.
- Transitions:
  - READY, idx==num_msgs (including num_msgs==0 immediately after reset) -> DONE.
  - READY, accept, idx+1==num_msgs -> DONE. This has priority over delay.
  - READY, accept, delay_amt==0 -> stay READY. This gives back-to-back accepts, one per cycle.
  - READY, accept, delay_amt>0 -> WAIT, count <= delay_amt-1.
  - WAIT, count==0 -> READY; otherwise count <= count-1.
  - DONE stays until reset.
- Delay timing: in_rdy is low for exactly delay_amt cycles between consecutive accepts, sampled at accept time. Changes to delay_amt during WAIT have no effect.
- done = (state==DONE), registered via the state.
- Table:
  - 1 write port, 1 combinational read port at idx.
  - A write in the same cycle as a compare to the same address: the compare uses the old contents.
  - Writes are allowed in any state.
- Widths: count is 32 bits and never underflows, because WAIT exits at 0. idx saturates at num_msgs.
- Reset mid-operation (in WAIT or READY): returns to READY, idx 0, flags cleared. The next accepted message is checked against tbl[0].
- in_val low: no state change except the WAIT countdown. Message content while in_val is low is ignored.
- Assertions when !reset: delay_amt, in_val, in_rdy not X.

Decomposition:
- Shared package test_sink_pkg: state encoding constants (READY, WAIT, DONE) and the c_state_nbits width.
- One natural sub-module, test_delay_ctr: a 32-bit down-counter.
  - Interface: load, load_val, dec, is_zero.
  - Reset to 0; load has priority over dec.
  - Reusable by source-side blocks.

Test Plan:
- Zero delay: num_msgs=4, tbl={0x11,0x22,0x33,0x44}, delay_amt=0, in_val held high with matching msgs -> 4 accepts in 4 consecutive cycles; done=1 the cycle after the 4th accept; error=0.
- Delay 3: num_msgs=2, delay_amt=3 -> accept at cycle t, in_rdy=0 for cycles t+1..t+3, second accept at t+4, done at t+5.
- Mismatch: tbl={0xAA,0xBB,0xCC}, send {0xAA,0x5B,0x00} -> error=1 after the 2nd accept; err_idx=1, err_got=0x5B; 3rd mismatch leaves err_idx=1 and err_got=0x5B.
- num_msgs=0 after reset -> in_rdy never asserts; done=1 one cycle after reset deasserts.
- Reset mid-WAIT: delay_amt=10, reset 4 cycles after an accept -> next cycle state READY, in_rdy=1, idx=0, error=0; the next message is compared against tbl[0].
- Same-cycle write/compare: tbl[0]=0x10, in_msg=0x10 accepted while writing tbl[0]=0x20 -> error stays 0; a later read of tbl[0] after reset returns 0x20.

Source files
------------

// File: rtl/test_sink_pkg.sv
// ---------------------------------------------------------------------------
// test_sink_pkg
// Shared definitions for the val/rdy test sink and its delay counter.
//   c_state_nbits : width of the one-hot sink state vector
//   c_delay_nbits : width of the back-pressure delay counter
//   state_t       : sink states (READY, WAIT, DONE), one bit per state
// ---------------------------------------------------------------------------
package test_sink_pkg;

    localparam int c_state_nbits = 3;
    localparam int c_delay_nbits = 32;

    typedef enum logic [c_state_nbits-1:0] {
        ST_READY = 3'b001,
        ST_WAIT  = 3'b010,
        ST_DONE  = 3'b100
    } state_t;

endpackage

// File: rtl/test_delay_ctr.sv
// ---------------------------------------------------------------------------
// test_delay_ctr
// Loadable down-counter used to time back-pressure / injected delay.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero, never wraps
//   is_zero    : count is zero
// ---------------------------------------------------------------------------
module test_delay_ctr
    import test_sink_pkg::*;
#(
    parameter int p_nbits = c_delay_nbits
)(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [p_nbits-1:0] load_val,
    input  logic               dec,
    output logic               is_zero
);

    logic [p_nbits-1:0] r_count;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {p_nbits{1'b0}};
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && !is_zero) begin
            r_count <= r_count - {{(p_nbits-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign is_zero = (r_count == {p_nbits{1'b0}});

endmodule

// File: rtl/test_delay_sink_chk.sv
// ---------------------------------------------------------------------------
// test_delay_sink_chk
// Property checker for test_delay_sink: control inputs and in_rdy must be
// known whenever the sink is out of reset.
// Ports: clk, reset, delay_amt, in_val, in_rdy (all inputs, observed only)
// ---------------------------------------------------------------------------
module test_delay_sink_chk (
    input logic        clk,
    input logic        reset,
    input logic [31:0] delay_amt,
    input logic        in_val,
    input logic        in_rdy
);

    a_ctrl_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({delay_amt, in_val, in_rdy}));

endmodule

// File: rtl/test_delay_sink.sv
// ---------------------------------------------------------------------------
// test_delay_sink
// Receiving end of a val/rdy test path. Checks each accepted message against
// an expected table, then drops in_rdy for delay_amt cycles.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   delay_amt             : in_rdy low cycles after each accept (sampled at accept)
//   num_msgs              : number of messages expected
//   tbl_wr_en/addr/data   : expected-table write port (any state)
//   in_val, in_rdy, in_msg: input message handshake
//   done                  : all num_msgs messages accepted
//   error                 : sticky mismatch flag
//   err_idx, err_got      : index and value of the first mismatch
// ---------------------------------------------------------------------------
module test_delay_sink
    import test_sink_pkg::*;
#(
    parameter  int p_msg_nbits   = 8,
    parameter  int p_num_msgs    = 1024,
    localparam int c_index_nbits = $clog2(p_num_msgs)
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              delay_amt,
    input  logic [c_index_nbits:0]   num_msgs,
    input  logic                     tbl_wr_en,
    input  logic [c_index_nbits-1:0] tbl_wr_addr,
    input  logic [p_msg_nbits-1:0]   tbl_wr_data,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [p_msg_nbits-1:0]   in_msg,
    output logic                     done,
    output logic                     error,
    output logic [c_index_nbits:0]   err_idx,
    output logic [p_msg_nbits-1:0]   err_got
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_index_nbits:0]   r_idx;
    logic [c_index_nbits:0]   w_idx_inc;
    logic                     r_error;
    logic [c_index_nbits:0]   r_err_idx;
    logic [p_msg_nbits-1:0]   r_err_got;
    logic [p_msg_nbits-1:0]   r_tbl [p_num_msgs];
    logic [p_msg_nbits-1:0]   w_tbl_rd;
    logic                     w_accept;
    logic                     w_ctr_load;
    logic                     w_ctr_dec;
    logic                     w_ctr_zero;

    assign w_idx_inc = r_idx + {{c_index_nbits{1'b0}}, 1'b1};
    // Read is combinational, so a same-cycle write is only seen next cycle.
    assign w_tbl_rd  = r_tbl[r_idx[c_index_nbits-1:0]];
    assign in_rdy    = (r_state == ST_READY) && (r_idx < num_msgs);
    assign w_accept  = in_val && in_rdy;
    assign done      = (r_state == ST_DONE);
    assign error     = r_error;
    assign err_idx   = r_err_idx;
    assign err_got   = r_err_got;

    // Expected-message table; deliberately not reset so it survives reset.
    always_ff @(posedge clk) begin
        if (tbl_wr_en) begin
            r_tbl[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and delay-counter control.
    always_comb begin
        w_state_next = r_state;
        w_ctr_load   = 1'b0;
        w_ctr_dec    = 1'b0;
        case (r_state)
            ST_READY: begin
                if (r_idx >= num_msgs) begin
                    w_state_next = ST_DONE;
                end else if (w_accept) begin
                    // Finishing takes priority over the post-accept delay.
                    if (w_idx_inc == num_msgs) begin
                        w_state_next = ST_DONE;
                    end else if (delay_amt == 32'd0) begin
                        w_state_next = ST_READY;
                    end else begin
                        // Load delay-1: WAIT lasts counts delay-1..0 = delay cycles.
                        w_state_next = ST_WAIT;
                        w_ctr_load   = 1'b1;
                    end
                end else begin
                    w_state_next = ST_READY;
                end
            end
            ST_WAIT: begin
                if (w_ctr_zero) begin
                    w_state_next = ST_READY;
                end else begin
                    w_ctr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_DONE;
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    // Message index; cannot pass num_msgs because in_rdy gates accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx <= {(c_index_nbits+1){1'b0}};
        end else if (w_accept) begin
            r_idx <= w_idx_inc;
        end else begin
            r_idx <= r_idx;
        end
    end

    // First-mismatch capture; later mismatches leave the record untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error   <= 1'b0;
            r_err_idx <= {(c_index_nbits+1){1'b0}};
            r_err_got <= {p_msg_nbits{1'b0}};
        end else if (w_accept && (in_msg != w_tbl_rd) && !r_error) begin
            r_error   <= 1'b1;
            r_err_idx <= r_idx;
            r_err_got <= in_msg;
        end else begin
            r_error   <= r_error;
            r_err_idx <= r_err_idx;
            r_err_got <= r_err_got;
        end
    end

    test_delay_ctr #(
        .p_nbits  (c_delay_nbits)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (w_ctr_load),
        .load_val (delay_amt - 32'd1),
        .dec      (w_ctr_dec),
        .is_zero  (w_ctr_zero)
    );

    test_delay_sink_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .delay_amt (delay_amt),
        .in_val    (in_val),
        .in_rdy    (in_rdy)
    );

endmodule

// File: tb/tb_test_delay_sink.sv
// ---------------------------------------------------------------------------
// tb_test_delay_sink
// Self-checking bench for test_delay_sink: directed vector table, hand-written
// multi-cycle corner cases, and randomized runs against a behavioural model.
// ---------------------------------------------------------------------------
module tb_test_delay_sink;

    localparam int MW = 8;
    localparam int NM = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   delay_amt = 32'd0;
    logic [IW:0]   num_msgs = '0;
    logic          tbl_wr_en = 1'b0;
    logic [IW-1:0] tbl_wr_addr = '0;
    logic [MW-1:0] tbl_wr_data = '0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [MW-1:0] in_msg = '0;
    logic          done;
    logic          error;
    logic [IW:0]   err_idx;
    logic [MW-1:0] err_got;

    always #5 clk = ~clk;

    test_delay_sink #(.p_msg_nbits(MW), .p_num_msgs(NM)) dut (
        .clk(clk), .reset(reset), .delay_amt(delay_amt), .num_msgs(num_msgs),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .done(done), .error(error), .err_idx(err_idx), .err_got(err_got)
    );

    logic [MW-1:0] m_tbl [NM];   // reference copy of the expected table
    logic [MW-1:0] msgs  [NM];   // messages to send, in order
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        int             num;
        int             dly;
        logic [3:0][7:0] tbl;
        logic [3:0][7:0] msg;
        logic           exp_err;
        logic [4:0]     exp_eidx;
        logic [7:0]     exp_egot;
        int             exp_span;   // last accept - first accept; -1 = no accepts
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic write_tbl(input int a, input logic [7:0] d);
        @(negedge clk);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = a[IW-1:0];
        tbl_wr_data = d;
        m_tbl[a]    = d;
        @(negedge clk);
        tbl_wr_en   = 1'b0;
    endtask

    // Leaves the bench at the negedge of the first cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    // Drive msgs[] and check every cycle against the rule-level model:
    // in_rdy is high only while messages remain and delay cycles have elapsed.
    task automatic run_seq(input int num, input int dmax, input int jitter, input int val_pct,
                           input int max_cyc, output int first_acc, output int last_acc,
                           output int done_cyc);
        int   acc = 0;
        int   wait_left = 0;
        bit   done_m = 1'b0;
        bit   err_m = 1'b0;
        bit   finished = 1'b0;
        logic [4:0] eidx = '0;
        logic [7:0] egot = '0;
        bit   exp_rdy;
        first_acc = -1;
        last_acc  = -1;
        done_cyc  = -1;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            exp_rdy = (acc < num) && (wait_left == 0);
            check("in_rdy",  {31'd0, in_rdy}, {31'd0, exp_rdy});
            check("done",    {31'd0, done},   {31'd0, done_m});
            check("error",   {31'd0, error},  {31'd0, err_m});
            check("err_idx", {27'd0, err_idx}, {27'd0, eidx});
            check("err_got", {24'd0, err_got}, {24'd0, egot});
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (done_m) begin
                finished = 1'b1;
                break;
            end
            delay_amt = (jitter != 0) ? $urandom_range(dmax, 0) : dmax;
            in_val    = ($urandom_range(99, 0) < val_pct);
            in_msg    = (in_val && acc < NM) ? msgs[acc] : 8'($urandom);
            if (in_val && in_rdy === 1'b1) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (in_val && exp_rdy) begin
                if (msgs[acc] !== m_tbl[acc] && !err_m) begin
                    err_m = 1'b1;
                    eidx  = acc[4:0];
                    egot  = msgs[acc];
                end
                acc++;
                wait_left = int'(delay_amt);
            end else if (wait_left > 0) begin
                wait_left--;
            end
            if (acc >= num) done_m = 1'b1;
            @(negedge clk);
        end
        in_val = 1'b0;
        check("finished", {31'd0, finished}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa, la, dc;

        vecs[0] = '{num:4, dly:0, tbl:{8'h44, 8'h33, 8'h22, 8'h11}, msg:{8'h44, 8'h33, 8'h22, 8'h11},
                    exp_err:1'b0, exp_eidx:5'd0, exp_egot:8'h00, exp_span:3};
        vecs[1] = '{num:2, dly:3, tbl:{8'h00, 8'h00, 8'hC3, 8'h5A}, msg:{8'h00, 8'h00, 8'hC3, 8'h5A},
                    exp_err:1'b0, exp_eidx:5'd0, exp_egot:8'h00, exp_span:4};
        vecs[2] = '{num:3, dly:0, tbl:{8'h00, 8'hCC, 8'hBB, 8'hAA}, msg:{8'h00, 8'h00, 8'h5B, 8'hAA},
                    exp_err:1'b1, exp_eidx:5'd1, exp_egot:8'h5B, exp_span:2};
        vecs[3] = '{num:0, dly:2, tbl:{8'h01, 8'h01, 8'h01, 8'h01}, msg:{8'h01, 8'h01, 8'h01, 8'h01},
                    exp_err:1'b0, exp_eidx:5'd0, exp_egot:8'h00, exp_span:-1};
        vecs[4] = '{num:4, dly:1, tbl:{8'h04, 8'h03, 8'h02, 8'h01}, msg:{8'h04, 8'hFF, 8'h02, 8'h00},
                    exp_err:1'b1, exp_eidx:5'd0, exp_egot:8'h00, exp_span:6};
        vecs[5] = '{num:1, dly:5, tbl:{8'h00, 8'h00, 8'h00, 8'h7E}, msg:{8'h00, 8'h00, 8'h00, 8'h7E},
                    exp_err:1'b0, exp_eidx:5'd0, exp_egot:8'h00, exp_span:0};

        repeat (2) @(negedge clk);

        // Directed vector table, in_val held high.
        for (int i = 0; i < 6; i++) begin
            num_msgs = vecs[i].num[IW:0];
            for (int j = 0; j < 4; j++) begin
                write_tbl(j, vecs[i].tbl[j]);
                msgs[j] = vecs[i].msg[j];
            end
            do_reset();
            run_seq(vecs[i].num, vecs[i].dly, 0, 100, 200, fa, la, dc);
            check("vec_error",   {31'd0, error},   {31'd0, vecs[i].exp_err});
            check("vec_err_idx", {27'd0, err_idx}, {27'd0, vecs[i].exp_eidx});
            check("vec_err_got", {24'd0, err_got}, {24'd0, vecs[i].exp_egot});
            if (vecs[i].exp_span >= 0) begin
                check("vec_span",     la - fa, vecs[i].exp_span);
                check("vec_done_off", dc - la, 32'd1);
            end else begin
                check("vec_no_accept", fa, -1);
                check("vec_done_cyc",  dc, 32'd1);
            end
        end

        // Reset in the middle of a long WAIT.
        num_msgs = 5'd3;
        write_tbl(0, 8'h10);
        write_tbl(1, 8'h20);
        write_tbl(2, 8'h30);
        do_reset();
        check("midw_rdy0", {31'd0, in_rdy}, 32'd1);
        delay_amt = 32'd10;
        in_val = 1'b1;
        in_msg = 8'h10;
        @(negedge clk);
        in_val = 1'b0;
        repeat (3) @(negedge clk);
        check("midw_waiting", {31'd0, in_rdy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midw_rdy",   {31'd0, in_rdy}, 32'd1);
        check("midw_error", {31'd0, error},  32'd0);
        check("midw_done",  {31'd0, done},   32'd0);
        in_val = 1'b1;
        in_msg = 8'h99;
        @(negedge clk);
        in_val = 1'b0;
        check("midw_err_set", {31'd0, error},   32'd1);
        check("midw_err_idx", {27'd0, err_idx}, 32'd0);
        check("midw_err_got", {24'd0, err_got}, 32'h99);

        // Write and compare to the same entry in the same cycle.
        num_msgs = 5'd2;
        write_tbl(0, 8'h10);
        write_tbl(1, 8'h55);
        do_reset();
        delay_amt   = 32'd0;
        in_val      = 1'b1;
        in_msg      = 8'h10;
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = 4'd0;
        tbl_wr_data = 8'h20;
        @(negedge clk);
        in_val    = 1'b0;
        tbl_wr_en = 1'b0;
        m_tbl[0]  = 8'h20;
        check("wrcmp_old", {31'd0, error}, 32'd0);
        do_reset();
        in_val = 1'b1;
        in_msg = 8'h10;
        @(negedge clk);
        in_val = 1'b0;
        check("wrcmp_new_err", {31'd0, error},   32'd1);
        check("wrcmp_new_got", {24'd0, err_got}, 32'h10);
        do_reset();
        in_val = 1'b1;
        in_msg = 8'h20;
        @(negedge clk);
        in_val = 1'b0;
        check("wrcmp_new_ok", {31'd0, error}, 32'd0);

        // Randomized runs: random table, occasional corrupt messages,
        // random delay (optionally changing every cycle) and in_val density.
        for (int r = 0; r < 25; r++) begin
            int num;
            int dmax;
            num  = $urandom_range(NM, 0);
            dmax = $urandom_range(6, 0);
            for (int j = 0; j < NM; j++) begin
                write_tbl(j, 8'($urandom));
                msgs[j] = ($urandom_range(3, 0) == 0) ? 8'($urandom) : m_tbl[j];
            end
            num_msgs = num[IW:0];
            do_reset();
            run_seq(num, dmax, $urandom_range(1, 0), $urandom_range(100, 30), 2000, fa, la, dc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
